// File: rtl/hazard_stall_unit.sv
// Load-use, branch-squash and multi-cycle freeze control; combinational outputs, registered RUN/MC_BUSY state.
// Optional HAZARD_PERF_CNT_EN adds 32-bit wrapping perf counters (perf_load_use, perf_mc_stall, perf_flush).
module hazard_stall_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_memread,
  input  logic                  branch_taken,
  input  logic                  mc_start,
  input  logic                  mc_done,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mc_busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           perf_load_use,
  output logic [31:0]           perf_mc_stall,
  output logic [31:0]           perf_flush,
`endif
  output logic                  mc_timeout
);

  localparam int CNT_W = $clog2(MC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load_use;
  logic             w_lu_bubble;
  logic             w_br_flush;

  assign w_load_use = id_ex_memread && (id_ex_rd != '0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mc_busy      = 1'b0;
    mc_timeout   = 1'b0;
    w_lu_bubble  = 1'b0;
    w_br_flush   = 1'b0;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      w_state_nxt  = RUN;
      w_cnt_nxt    = '0;
    end else if (r_state == RUN) begin
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        w_br_flush  = 1'b1;
      end else if (mc_start && !mc_done) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
        w_state_nxt  = MC_BUSY;
        w_cnt_nxt    = CNT_W'(1);
      end else if (!mc_start && w_load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        w_lu_bubble = 1'b1;
      end
    end else begin
      mc_busy = 1'b1;
      if (mc_done) begin
        // Release lets the result into EX/MEM; a pending load-use still gets its bubble.
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
        if (w_load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          w_lu_bubble = 1'b1;
        end
      end else if (r_cnt == CNT_LAST) begin
        mc_timeout   = 1'b1;
        ex_mem_flush = 1'b1;
        w_state_nxt  = RUN;
        w_cnt_nxt    = '0;
      end else begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_lu;
  logic [31:0] r_perf_mc;
  logic [31:0] r_perf_fl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_lu <= '0;
      r_perf_mc <= '0;
      r_perf_fl <= '0;
    end else begin
      if (w_lu_bubble) r_perf_lu <= r_perf_lu + 32'd1;
      if (mc_busy)     r_perf_mc <= r_perf_mc + 32'd1;
      if (w_br_flush)  r_perf_fl <= r_perf_fl + 32'd1;
    end
  end

  assign perf_load_use = r_perf_lu;
  assign perf_mc_stall = r_perf_mc;
  assign perf_flush    = r_perf_fl;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit with MC_TIMEOUT=8.
// Output vector order: pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush, mc_busy, mc_timeout.
module tb_hazard_stall_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] if_id_rs1 = '0, if_id_rs2 = '0, id_ex_rd = '0;
  logic       id_ex_memread = 1'b0, branch_taken = 1'b0, mc_start = 1'b0, mc_done = 1'b0;
  logic       pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic       mc_busy, mc_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_load_use, perf_mc_stall, perf_flush;
`endif
  int n_checks = 0;
  int n_fail = 0;

  localparam logic [7:0] V_RST  = 8'h1C;
  localparam logic [7:0] V_DEF  = 8'hE0;
  localparam logic [7:0] V_LU   = 8'h28;
  localparam logic [7:0] V_BR   = 8'hF8;
  localparam logic [7:0] V_MCS  = 8'h04;
  localparam logic [7:0] V_BUSY = 8'h06;
  localparam logic [7:0] V_REL  = 8'hE2;
  localparam logic [7:0] V_RLU  = 8'h2A;
  localparam logic [7:0] V_TO   = 8'hE7;

  hazard_stall_unit #(.REG_ADDR_W(5), .MC_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .branch_taken(branch_taken),
    .mc_start(mc_start), .mc_done(mc_done),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mc_busy(mc_busy),
`ifdef HAZARD_PERF_CNT_EN
    .perf_load_use(perf_load_use), .perf_mc_stall(perf_mc_stall), .perf_flush(perf_flush),
`endif
    .mc_timeout(mc_timeout)
  );

  always #5 clk = ~clk;

  wire [7:0] w_obs = {pc_write, if_id_write, id_ex_write, if_id_flush,
                      id_ex_flush, ex_mem_flush, mc_busy, mc_timeout};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic br, input logic ms, input logic md, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    branch_taken  = br;
    mc_start      = ms;
    mc_done       = md;
    id_ex_memread = mr;
    id_ex_rd      = rd;
    if_id_rs1     = rs1;
    if_id_rs2     = rs2;
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic step_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, w_obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    chk("reset", w_obs, V_RST);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step_chk("idle", V_DEF);

    drive(0, 0, 0, 1, 5'd5, 5'd3, 5'd5);
    step_chk("lu_rs2", V_LU);
    drive(0, 0, 0, 0, 5'd5, 5'd3, 5'd5);
    step_chk("lu_after", V_DEF);
    drive(0, 0, 0, 1, 5'd7, 5'd7, 5'd1);
    step_chk("lu_rs1", V_LU);
    drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    step_chk("lu_x0", V_DEF);
    drive(0, 0, 0, 1, 5'd6, 5'd2, 5'd3);
    step_chk("lu_nomatch", V_DEF);

    drive(1, 1, 0, 1, 5'd5, 5'd3, 5'd5);
    step_chk("br_prio", V_BR);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("br_stays_run", V_DEF);

    drive(0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    step_chk("mc_single", V_DEF);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("mc_single_run", V_DEF);

    // mc_start at cycle 0, mc_done at cycle 4; busy ignores branch and load-use.
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("mc_c0", V_MCS);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("mc_c1", V_BUSY);
    drive(1, 1, 0, 1, 5'd5, 5'd5, 5'd0);
    step_chk("mc_c2_ignore", V_BUSY);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("mc_c3", V_BUSY);
    drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    step_chk("mc_c4_rel", V_REL);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("mc_c5_run", V_DEF);

    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("mclu_c0", V_MCS);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("mclu_c1", V_BUSY);
    drive(0, 0, 1, 1, 5'd9, 5'd9, 5'd0);
    step_chk("mclu_rel_lu", V_RLU);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("mclu_run", V_DEF);

    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("wd_c0", V_MCS);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i <= 6; i++) step_chk("wd_busy", V_BUSY);
    step_chk("wd_timeout", V_TO);
    step_chk("wd_run", V_DEF);

    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("wdd_c0", V_MCS);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i <= 6; i++) step_chk("wdd_busy", V_BUSY);
    drive(0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    step_chk("wdd_done_wins", V_REL);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("wdd_run", V_DEF);

    // Reset asserted while cnt=3 in MC_BUSY.
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("rst_c0", V_MCS);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("rst_c1", V_BUSY);
    step_chk("rst_c2", V_BUSY);
    rst_n = 1'b0;
    step_chk("rst_mid_busy", V_RST);
    rst_n = 1'b1;
    step_chk("rst_back_run", V_DEF);
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    step_chk("rst_fresh_c0", V_MCS);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i <= 6; i++) step_chk("rst_fresh_busy", V_BUSY);
    step_chk("rst_fresh_timeout", V_TO);
    step_chk("rst_fresh_run", V_DEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Counterpart to the pipeline's forwarding logic: it handles the hazards that bypassing cannot resolve, and generates stall and flush controls.
- Detects load-use hazards between the ID and EX stages.
- Squashes wrong-path instructions on a taken branch.
- Freezes the front end while a multi-cycle EX operation (mul/div) is busy, with a watchdog timeout.
- Sits beside the forwarding unit. Its outputs drive the PC, IF/ID, ID/EX and EX/MEM register enables and flushes.

Parameters:
- REG_ADDR_W, 5, register-index width.
- MC_TIMEOUT, 64, maximum MC_BUSY cycles before the watchdog releases the pipeline (>=2).

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- if_id_rs1  input  REG_ADDR_W  rs1 of the instruction in ID.
- if_id_rs2  input  REG_ADDR_W  rs2 of the instruction in ID.
- id_ex_rd  input  REG_ADDR_W  destination register of the instruction in EX.
- id_ex_memread  input  1  instruction in EX is a load.
- branch_taken  input  1  EX resolved a taken branch or jump this cycle.
- mc_start  input  1  multi-cycle op in EX begins this cycle.
- mc_done  input  1  multi-cycle unit result is valid this cycle.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID load enable.
- id_ex_write  output  1  ID/EX load enable.
- if_id_flush  output  1  clear IF/ID to a NOP.
- id_ex_flush  output  1  load a bubble into ID/EX.
- ex_mem_flush  output  1  load a bubble into EX/MEM.
- mc_busy  output  1  FSM is in MC_BUSY.
- mc_timeout  output  1  one-cycle watchdog release pulse.

Behaviour:
- Interface: one clock. Reset is asynchronous and active-low. Ports are named clk and rst_n.
- State: FSM {RUN, MC_BUSY} plus a cycle counter cnt of width clog2(MC_TIMEOUT+1). Reset gives RUN and cnt=0.
- Outputs are combinational from state and inputs.
  - While rst_n=0: all *_write=0, all *_flush=1, mc_busy=0, mc_timeout=0.
  - Default, when no rule below applies: all *_write=1, all *_flush=0.
- load_use = id_ex_memread && id_ex_rd!=0 && (id_ex_rd==if_id_rs1 || id_ex_rd==if_id_rs2).
- RUN, rules in priority order:
  1. branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1. load_use and mc_start are ignored. Stay in RUN.
  2. mc_start && !mc_done: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1. Next state MC_BUSY, cnt<=1.
  3. mc_start && mc_done (single-cycle completion): default outputs, stay in RUN.
  4. load_use: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble; this self-clears next cycle as the load advances.
- MC_BUSY (mc_busy=1):
  - Not done: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1, cnt<=cnt+1. branch_taken, mc_start and load_use are ignored.
  - mc_done: release. Writes=1, ex_mem_flush=0 so the result enters EX/MEM. load_use is evaluated as in RUN. Next state RUN, cnt<=0.
  - cnt==MC_TIMEOUT-1 && !mc_done: mc_timeout=1, writes=1, ex_mem_flush=1 (result dropped). Next state RUN, cnt<=0.
  - mc_done and timeout in the same cycle: mc_done wins and mc_timeout=0.
- Latency: stall and flush take effect in the same cycle as the causing inputs. MC release takes effect in the mc_done cycle.
- Register 0 never causes a load-use stall.
- Reset mid-MC_BUSY returns immediately to RUN with cnt=0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds three 32-bit output ports, perf_load_use, perf_mc_stall and perf_flush. They are reset to 0 and wrap at 2^32.
  - perf_load_use: +1 per load-use bubble cycle.
  - perf_mc_stall: +1 per cycle with mc_busy=1.
  - perf_flush: +1 per branch_taken flush.
- Undefined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rd=5, if_id_rs2=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1. Next cycle, with memread=0, all writes=1.
- x0 case: same as above but id_ex_rd=0, if_id_rs1=0 -> no stall, all writes=1, flushes=0.
- Branch priority: branch_taken=1 together with load_use=1 and mc_start=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1, state stays RUN.
- Multi-cycle: mc_start at cycle 0, mc_done at cycle 4 -> cycles 0-3 frozen with ex_mem_flush=1 and mc_busy high for cycles 1-4. Cycle 4 releases with ex_mem_flush=0; cycle 5 is in RUN.
- Watchdog: MC_TIMEOUT=8, mc_start with no mc_done -> mc_timeout=1 in the 8th cycle after mc_start with ex_mem_flush=1, then RUN. Also check mc_done in that same cycle gives mc_timeout=0.
- Reset: assert rst_n=0 during MC_BUSY cnt=3 -> immediate RUN with all flushes=1. After release, a fresh mc_start times out after the full MC_TIMEOUT.
